// File: rtl/inst_fifo_pkg.sv
// Shared CPU definitions for the fetch/decode instruction queue.
//   INST_FIFO_DEPTH   : default number of queue entries
//   inst_fifo_entry_t : one queued instruction word with its PC
package inst_fifo_pkg;

  localparam int INST_FIFO_DEPTH = 16;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } inst_fifo_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// Decoupling instruction queue between fetch and dual-issue decode.
// Fetch pushes up to two {inst, pc} entries per cycle. Decode sees the two
// oldest entries (master/slave) first-word-fall-through and pops 0, 1 or 2
// entries per cycle.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   fifo_rst                : synchronous flush (mispredict/exception)
//   write_en1/2, write_*    : fetch push request, entry 1 is the older
//   read_en1/2              : master / slave consumed this cycle
//   read_inst1/2, read_address1/2 : head and head+1 entries, 0 when absent
//   fifo_empty/almost_empty/full  : status decoded from the occupancy count
module inst_fifo
  import inst_fifo_pkg::*;
#(
  parameter  int DEPTH = INST_FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_rst,
  input  logic        write_en1,
  input  logic        write_en2,
  input  logic [31:0] write_inst1,
  input  logic [31:0] write_inst2,
  input  logic [31:0] write_address1,
  input  logic [31:0] write_address2,
  input  logic        read_en1,
  input  logic        read_en2,
  output logic [31:0] read_inst1,
  output logic [31:0] read_inst2,
  output logic [31:0] read_address1,
  output logic [31:0] read_address2,
  output logic        fifo_empty,
  output logic        fifo_almost_empty,
  output logic        fifo_full
);

  inst_fifo_entry_t mem_q [DEPTH];
  inst_fifo_entry_t mem_d [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [PTR_W-1:0] wr_ptr_p1, rd_ptr_p1;
  logic [1:0]       push_n, pop_req, pop_n;
  logic             flush;

  inst_fifo_entry_t head, head_p1;

  assign flush     = rst | fifo_rst;
  assign wr_ptr_p1 = wr_ptr_q + PTR_W'(1);
  assign rd_ptr_p1 = rd_ptr_q + PTR_W'(1);

  // Status comes from the count only: at wrap wr_ptr == rd_ptr for both
  // empty and full, so the pointers cannot tell them apart.
  assign fifo_empty        = (count_q == '0);
  assign fifo_almost_empty = (count_q == (PTR_W+1)'(1));
  // Threshold one below capacity so a dual push is always safe when not full.
  assign fifo_full         = (count_q >= (PTR_W+1)'(DEPTH - 1));

  always_comb begin
    push_n  = 2'd0;
    pop_req = 2'd0;
    pop_n   = 2'd0;

    // write_en2 / read_en2 are only meaningful together with slot 1.
    // A push while full is dropped as a whole, never split.
    if (write_en1 && !fifo_full)
      push_n = write_en2 ? 2'd2 : 2'd1;
    if (read_en1)
      pop_req = read_en2 ? 2'd2 : 2'd1;

    // Pop uses the pre-edge count, so this cycle's pushes are not poppable.
    if ({{(PTR_W-1){1'b0}}, pop_req} > count_q)
      pop_n = count_q[1:0];
    else
      pop_n = pop_req;

    if (flush) begin
      push_n = 2'd0;
      pop_n  = 2'd0;
    end

    mem_d = mem_q;
    if (push_n != 2'd0)
      mem_d[wr_ptr_q] = '{inst: write_inst1, pc: write_address1};
    if (push_n == 2'd2)
      mem_d[wr_ptr_p1] = '{inst: write_inst2, pc: write_address2};

    wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_n);
    count_d  = count_q + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop_n);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; the count gates visibility.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head    = mem_q[rd_ptr_q];
  assign head_p1 = mem_q[rd_ptr_p1];

  always_comb begin
    read_inst1    = 32'd0;
    read_address1 = 32'd0;
    read_inst2    = 32'd0;
    read_address2 = 32'd0;
    if (count_q != '0) begin
      read_inst1    = head.inst;
      read_address1 = head.pc;
    end
    if (count_q >= (PTR_W+1)'(2)) begin
      read_inst2    = head_p1.inst;
      read_address2 = head_p1.pc;
    end
  end

endmodule

// File: tb/tb_inst_fifo.sv
module tb_inst_fifo;
  import inst_fifo_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst, fifo_rst;
  logic        write_en1, write_en2, read_en1, read_en2;
  logic [31:0] write_inst1, write_inst2, write_address1, write_address2;
  logic [31:0] read_inst1, read_inst2, read_address1, read_address2;
  logic        fifo_empty, fifo_almost_empty, fifo_full;

  inst_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .fifo_rst(fifo_rst),
    .write_en1(write_en1), .write_en2(write_en2),
    .write_inst1(write_inst1), .write_inst2(write_inst2),
    .write_address1(write_address1), .write_address2(write_address2),
    .read_en1(read_en1), .read_en2(read_en2),
    .read_inst1(read_inst1), .read_inst2(read_inst2),
    .read_address1(read_address1), .read_address2(read_address2),
    .fifo_empty(fifo_empty), .fifo_almost_empty(fifo_almost_empty),
    .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst, frst, we1, we2, re1, re2;
    logic [31:0] i1, a1, i2, a2;
    int          exp_count;
  } vec_t;

  inst_fifo_entry_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic vec_t mk(bit r, bit f, bit w1, bit w2, bit r1, bit r2,
                              logic [31:0] i1, logic [31:0] a1,
                              logic [31:0] i2, logic [31:0] a2, int ec);
    vec_t v;
    v.rst = r; v.frst = f; v.we1 = w1; v.we2 = w2; v.re1 = r1; v.re2 = r2;
    v.i1 = i1; v.a1 = a1; v.i2 = i2; v.a2 = a2; v.exp_count = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input vec_t v);
    int pop_n, push_n;
    rst = v.rst; fifo_rst = v.frst;
    write_en1 = v.we1; write_en2 = v.we2; read_en1 = v.re1; read_en2 = v.re2;
    write_inst1 = v.i1; write_address1 = v.a1;
    write_inst2 = v.i2; write_address2 = v.a2;
    if (v.rst || v.frst) begin
      sb.delete();
    end else begin
      push_n = (v.we1 && sb.size() < DEPTH - 1) ? (v.we2 ? 2 : 1) : 0;
      pop_n  = v.re1 ? (v.re2 ? 2 : 1) : 0;
      if (pop_n > sb.size()) pop_n = sb.size();
      repeat (pop_n) void'(sb.pop_front());
      if (push_n >= 1) sb.push_back('{inst: v.i1, pc: v.a1});
      if (push_n == 2) sb.push_back('{inst: v.i2, pc: v.a2});
    end
    @(posedge clk);
    #1;
    chk("fifo_empty",        {31'd0, fifo_empty},        {31'd0, v.exp_count == 0});
    chk("fifo_almost_empty", {31'd0, fifo_almost_empty}, {31'd0, v.exp_count == 1});
    chk("fifo_full",         {31'd0, fifo_full},         {31'd0, v.exp_count >= DEPTH - 1});
    chk("read_inst1",    read_inst1,    sb.size() >= 1 ? sb[0].inst : 32'd0);
    chk("read_address1", read_address1, sb.size() >= 1 ? sb[0].pc   : 32'd0);
    chk("read_inst2",    read_inst2,    sb.size() >= 2 ? sb[1].inst : 32'd0);
    chk("read_address2", read_address2, sb.size() >= 2 ? sb[1].pc   : 32'd0);
  endtask

  task automatic push_pair(input logic [31:0] pc, input int ec);
    step(mk(0, 0, 1, 1, 0, 0, 32'h1000_0000 | pc, pc, 32'h1000_0000 | (pc + 4), pc + 4, ec));
  endtask

  task automatic pop_pair(input int ec);
    step(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, ec));
  endtask

  vec_t tbl[15];
  logic [31:0] pc;

  initial begin
    //               rst f w1 w2 r1 r2  inst1         addr1         inst2         addr2        cnt
    tbl[0]  = mk(1, 0, 1, 0, 0, 0, 32'h1111_1111, 32'h0000_0040, 0, 0, 0);
    tbl[1]  = mk(1, 0, 1, 0, 0, 0, 32'h2222_2222, 32'h0000_0044, 0, 0, 0);
    tbl[2]  = mk(0, 0, 1, 1, 0, 0, 32'h2401_0001, 32'hBFC0_0000, 32'h2402_0002, 32'hBFC0_0004, 2);
    tbl[3]  = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 1, 0, 0, 0, 32'h0000_000A, 32'h0000_0100, 0, 0, 1);
    tbl[5]  = mk(0, 0, 1, 1, 1, 0, 32'h0000_000B, 32'h0000_0104, 32'h0000_000C, 32'h0000_0108, 2);
    tbl[6]  = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 1, 0, 0, 0, 32'h0000_000D, 32'h0000_010C, 0, 0, 1);
    tbl[8]  = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    tbl[9]  = mk(0, 0, 1, 1, 0, 0, 32'h0000_000E, 32'h0000_0110, 32'h0000_000F, 32'h0000_0114, 2);
    tbl[10] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2);
    tbl[11] = mk(0, 0, 0, 1, 0, 0, 32'hDEAD_0001, 32'h0000_0200, 32'hDEAD_0002, 32'h0000_0204, 2);
    tbl[12] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    tbl[13] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);

    for (int i = 0; i < 15; i++) step(tbl[i]);

    // Fill to full (odd count), try an extra push, then drain across the wrap.
    pc = 32'h8000_0000;
    step(mk(0, 0, 1, 0, 0, 0, 32'h1000_0000 | pc, pc, 0, 0, 1));
    pc += 4;
    for (int k = 0; k < 7; k++) begin
      push_pair(pc, 3 + 2 * k);
      pc += 8;
    end
    push_pair(pc, 15);
    pc += 8;
    for (int k = 0; k < 7; k++) pop_pair(13 - 2 * k);
    pop_pair(0);

    // Dual push with dual pop at DEPTH-2 keeps the count.
    for (int k = 0; k < 7; k++) begin
      push_pair(pc, 2 + 2 * k);
      pc += 8;
    end
    step(mk(0, 0, 1, 1, 1, 1, 32'h1000_0000 | pc, pc,
            32'h1000_0000 | (pc + 4), pc + 4, 14));
    pc += 8;
    for (int k = 0; k < 7; k++) pop_pair(12 - 2 * k);

    // Flush wins over simultaneous push and pop.
    for (int k = 0; k < 3; k++) begin
      push_pair(pc, 2 + 2 * k);
      pc += 8;
    end
    step(mk(0, 1, 1, 1, 1, 1, 32'h5555_0001, pc, 32'h5555_0002, pc + 4, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fifo.md
Name: inst_fifo

Overview:
Decoupling instruction queue between the fetch stage and the dual-issue decode stage.
- Fetch side: accepts up to two fetched instructions, each with its PC, per cycle.
- Decode side: presents the two oldest entries, as master and slave, in first-word-fall-through form.
- Decode side: pops 0, 1 or 2 entries per cycle, according to master issue and the dual-issue decision.
- Drives the fifo_empty / fifo_almost_empty status consumed by the dual-issue detect logic.

Parameters:
DEPTH, 16, number of entries; power of two, minimum 4.
PTR_W, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
fifo_rst  input  1  synchronous flush (branch mispredict/exception); same effect as rst on queue state
write_en1  input  1  push entry 1 (older of the pair)
write_en2  input  1  push entry 2; honoured only together with write_en1
write_inst1  input  32  instruction word 1
write_inst2  input  32  instruction word 2
write_address1  input  32  PC of instruction 1
write_address2  input  32  PC of instruction 2
read_en1  input  1  master consumed head entry
read_en2  input  1  slave consumed head+1 entry (dual-issued)
read_inst1  output  32  head instruction (master)
read_inst2  output  32  head+1 instruction (slave)
read_address1  output  32  head PC
read_address2  output  32  head+1 PC
fifo_empty  output  1  count == 0
fifo_almost_empty  output  1  count == 1
fifo_full  output  1  count >= DEPTH-1; fetch must not push

Behaviour:
- State:
  - Storage array of {inst, pc}.
  - Pointers: wr_ptr and rd_ptr, PTR_W bits, modulo-DEPTH wrap.
  - count: PTR_W+1 bits.
- Reset / flush: rst or fifo_rst clears wr_ptr, rd_ptr and count to 0 on the next edge. Storage contents are not cleared.
  - After reset: fifo_empty=1, fifo_almost_empty=0, fifo_full=0, all read_* outputs = 0.
- Flush priority: when rst or fifo_rst is asserted, all push and pop requests in that cycle are discarded.
- Push amount:
  - push_n = write_en1 + (write_en1 & write_en2).
  - write_en2 alone is ignored, so push_n = 0.
  - Any push while fifo_full=1 is dropped entirely (push_n = 0), never partially.
- Push order:
  - Entry 1 is written at wr_ptr.
  - Entry 2 is written at wr_ptr+1 (wrap).
  - wr_ptr advances by push_n.
- Pop amount:
  - pop_n = read_en1 + (read_en1 & read_en2), then clamped to count.
  - read_en2 without read_en1 pops nothing.
  - A pop with count=0 pops nothing; read_en1&read_en2 with count=1 pops 1.
  - rd_ptr advances by the clamped pop_n.
- Count update:
  - count_next = count + push_n - pop_n in the same cycle.
  - Pop uses the pre-edge count: entries pushed this cycle are not poppable this cycle.
- Read outputs (combinational, zero latency):
  - read_inst1 / read_address1 = entry[rd_ptr] when count >= 1, else 0.
  - read_inst2 / read_address2 = entry[rd_ptr+1] when count >= 2, else 0.
- Latency: an entry pushed at edge N is visible on read_* after edge N.
- Status outputs are combinational from count only, never from pointers. This keeps them unambiguous at wrap, where wr_ptr == rd_ptr for both empty and full.
- fifo_full threshold is DEPTH-1, so a dual push is always safe when fifo_full=0.
- Simultaneous push 2 and pop 2 with count=DEPTH-2 is legal: count is unchanged and the pointers wrap correctly.

Decomposition:
- Shared CPU package gets:
  - typedef inst_fifo_entry_t, a struct of {logic [31:0] inst; logic [31:0] pc}.
  - Constant INST_FIFO_DEPTH = 16.
- No sub-module is required. Storage, pointer and count logic live inline; expected size is about 150 lines.

Test Plan:
- Reset: assert rst 2 cycles with write_en1=1 -> fifo_empty=1, fifo_almost_empty=0, fifo_full=0, read_inst1=0, read_inst2=0.
- Dual push then dual pop:
  - Push (0x24010001 @0xBFC00000, 0x24020002 @0xBFC00004) -> count 2, read_inst1=0x24010001, read_address2=0xBFC00004.
  - Then read_en1=read_en2=1 -> fifo_empty=1.
- Single pop with push:
  - count=1 (head 0xA), push pair (0xB, 0xC) and read_en1=1 the same cycle -> count 2, read_inst1=0xB, read_inst2=0xC.
- Full and wrap:
  - Push pairs until fifo_full=1 at count=15 (DEPTH=16); a further push is dropped and count stays 15.
  - Pop 2 per cycle and confirm PCs emerge in order across the pointer wrap.
- Clamping and illegal enables:
  - count=1 with read_en1=read_en2=1 -> count 0.
  - read_en2 alone -> count unchanged.
  - write_en2 alone -> count unchanged.
- Flush mid-operation: count=6, fifo_rst=1 together with push 2 and pop 2 -> next cycle count 0, fifo_empty=1, no entries visible.
